// File: rtl/min_pkg.sv
// Shared definitions for the streaming minimum finder and its tracker cell.
// Holds default widths, the frame-collection state type and the sentinel value.
package min_pkg;

  localparam int MIN_DATA_W = 4;
  localparam int MIN_N      = 16;
  localparam int MIN_IDX_W  = $clog2(MIN_N);

  localparam logic [MIN_DATA_W-1:0] MAX_VAL = {MIN_DATA_W{1'b1}};

  typedef enum logic {
    COLLECT = 1'b0,
    DONE    = 1'b1
  } state_t;

endpackage

// File: rtl/min_track_cell.sv
// Combinational update of the (smallest, second-smallest, index) tracker for one sample.
// Shared with the parallel-finder regression model, so it carries no state of its own.
module min_track_cell #(
  parameter int DATA_W = 4,
  parameter int IDX_W  = 4
) (
  input  logic [DATA_W-1:0] cur_min1,
  input  logic [DATA_W-1:0] cur_min2,
  input  logic [IDX_W-1:0]  cur_idx,
  input  logic [DATA_W-1:0] d,
  input  logic [IDX_W-1:0]  cnt,
  input  logic              first,
  output logic [DATA_W-1:0] nxt_min1,
  output logic [DATA_W-1:0] nxt_min2,
  output logic [IDX_W-1:0]  nxt_idx
);

  // Strict less-than keeps the earliest index on ties; an equal value falls through to min2.
  always_comb begin
    nxt_min1 = cur_min1;
    nxt_min2 = cur_min2;
    nxt_idx  = cur_idx;
    if (first) begin
      nxt_min1 = d;
      nxt_min2 = {DATA_W{1'b1}};
      nxt_idx  = '0;
    end else if (d < cur_min1) begin
      nxt_min2 = cur_min1;
      nxt_min1 = d;
      nxt_idx  = cnt;
    end else if (d < cur_min2) begin
      nxt_min2 = d;
    end
  end

endmodule

// File: rtl/min_stream_finder.sv
// Serial minimum finder: collects N samples per frame over valid/ready and presents
// the smallest, second-smallest and first index of the smallest on a registered result port.
module min_stream_finder
  import min_pkg::*;
#(
  parameter int DATA_W = MIN_DATA_W,
  parameter int N      = MIN_N,
  parameter int IDX_W  = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] min1,
  output logic [DATA_W-1:0] min2,
  output logic [IDX_W-1:0]  index_min1
);

  state_t            state;
  state_t            state_nxt;
  logic [IDX_W-1:0]  cnt;
  logic              accept;
  logic              last_beat;
  logic [DATA_W-1:0] cell_min1;
  logic [DATA_W-1:0] cell_min2;
  logic [IDX_W-1:0]  cell_idx;

  assign accept    = in_valid && (state == COLLECT);
  assign last_beat = (cnt == IDX_W'(N - 1));

  min_track_cell #(
    .DATA_W (DATA_W),
    .IDX_W  (IDX_W)
  ) u_cell (
    .cur_min1 (min1),
    .cur_min2 (min2),
    .cur_idx  (index_min1),
    .d        (in_data),
    .cnt      (cnt),
    .first    (cnt == '0),
    .nxt_min1 (cell_min1),
    .nxt_min2 (cell_min2),
    .nxt_idx  (cell_idx)
  );

  // Handshake flags depend only on the state register, never on inputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      COLLECT: begin
        in_ready = 1'b1;
        if (accept && last_beat) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = COLLECT;
      end
      default: state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= COLLECT;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (accept) cnt <= last_beat ? '0 : cnt + 1'b1;
    end
  end

  // Trackers only move on accepted beats, so they hold through gaps and the whole result phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      min1       <= {DATA_W{1'b1}};
      min2       <= {DATA_W{1'b1}};
      index_min1 <= '0;
    end else if (accept) begin
      min1       <= cell_min1;
      min2       <= cell_min2;
      index_min1 <= cell_idx;
    end
  end

endmodule

// File: tb/tb_min_stream_finder.sv
// Directed bench for min_stream_finder: hand-computed frames, gaps, backpressure and mid-frame reset.
module tb_min_stream_finder;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] min1;
  logic [3:0] min2;
  logic [3:0] index_min1;

  int errors = 0;
  int checks = 0;
  logic [3:0] frame [16];

  min_stream_finder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .min1       (min1),
    .min2       (min2),
    .index_min1 (index_min1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // One clock with the given input values, returning #1 after the active edge.
  task automatic applyStimulus(input logic valid, input logic [3:0] data);
    in_valid = valid;
    in_data  = data;
    @(posedge clk);
    #1;
  endtask

  // Sends frame[0..count-1], optionally inserting idle cycles between beats.
  task automatic sendBeats(input int count, input bit gaps);
    for (int i = 0; i < count; i++) begin
      if (gaps && ($urandom_range(0, 1) == 1)) begin
        for (int g = 0; g < int'($urandom_range(1, 3)); g++) applyStimulus(1'b0, 4'hA);
      end
      applyStimulus(1'b1, frame[i]);
    end
    in_valid = 1'b0;
  endtask

  task automatic checkResult(input string tag, input int e1, input int e2, input int eidx);
    checkOutput({tag, " out_valid"}, 32'(out_valid), 1);
    checkOutput({tag, " in_ready"}, 32'(in_ready), 0);
    checkOutput({tag, " min1"}, 32'(min1), 32'(e1));
    checkOutput({tag, " min2"}, 32'(min2), 32'(e2));
    checkOutput({tag, " index_min1"}, 32'(index_min1), 32'(eidx));
  endtask

  task automatic runFrame(input string tag, input bit gaps, input int e1, input int e2, input int eidx);
    sendBeats(15, gaps);
    checkOutput({tag, " not done before last"}, 32'(out_valid), 0);
    sendBeats(16, 1'b0) ;
  endtask

  task automatic finishHandshake(input string tag);
    out_ready = 1'b1;
    applyStimulus(1'b0, 4'h0);
    checkOutput({tag, " out_valid cleared"}, 32'(out_valid), 0);
    checkOutput({tag, " in_ready restored"}, 32'(in_ready), 1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 4'h0;
    out_ready = 1'b1;
    #12;
    checkOutput("reset out_valid", 32'(out_valid), 0);
    checkOutput("reset in_ready", 32'(in_ready), 1);
    checkOutput("reset min1", 32'(min1), 15);
    checkOutput("reset min2", 32'(min2), 15);
    checkOutput("reset index_min1", 32'(index_min1), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Frame 1: basic, result visible right after the 16th beat.
    frame = '{4'd2, 4'd3, 4'd1, 4'd2, 4'd5, 4'd6, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9};
    for (int i = 0; i < 15; i++) applyStimulus(1'b1, frame[i]);
    checkOutput("f1 not done before last", 32'(out_valid), 0);
    applyStimulus(1'b1, frame[15]);
    checkResult("f1", 1, 2, 2);
    finishHandshake("f1");

    // Frame 2: duplicate minimum keeps first index and becomes min2.
    frame = '{4'd1, 4'd4, 4'd2, 4'd1, 4'd2, 4'd12, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9};
    sendBeats(16, 1'b0);
    checkResult("f2", 1, 1, 0);
    finishHandshake("f2");

    // Frame 3: random idle gaps must not disturb the result.
    frame = '{4'd5, 4'd2, 4'd10, 4'd0, 4'd4, 4'd1, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9};
    sendBeats(16, 1'b1);
    checkResult("f3 gaps", 0, 1, 3);
    finishHandshake("f3");

    // Frame 4: all maximum values.
    for (int i = 0; i < 16; i++) frame[i] = 4'd15;
    sendBeats(16, 1'b0);
    checkResult("f4 all15", 15, 15, 0);
    finishHandshake("f4");

    // Frame 5: minimum in the last slot.
    frame[15] = 4'd0;
    sendBeats(16, 1'b0);
    checkResult("f5 last", 0, 15, 15);
    finishHandshake("f5");

    // Backpressure: result holds while out_ready is low and in_valid pushes data.
    frame = '{4'd2, 4'd3, 4'd1, 4'd2, 4'd5, 4'd6, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9, 4'd9};
    out_ready = 1'b0;
    sendBeats(16, 1'b0);
    for (int c = 0; c < 5; c++) applyStimulus(1'b1, 4'd0);
    checkResult("stall", 1, 2, 2);
    out_ready = 1'b1;
    applyStimulus(1'b1, 4'd0);
    checkOutput("stall released", 32'(out_valid), 0);
    in_valid = 1'b0;
    sendBeats(16, 1'b0);
    checkResult("after stall", 1, 2, 2);
    finishHandshake("after stall");

    // Mid-frame reset discards the partial frame.
    frame = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    sendBeats(7, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset out_valid", 32'(out_valid), 0);
    checkOutput("midreset in_ready", 32'(in_ready), 1);
    checkOutput("midreset min1", 32'(min1), 15);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    frame = '{4'd3, 4'd7, 4'd5, 4'd9, 4'd8, 4'd6, 4'd4, 4'd12, 4'd11, 4'd10, 4'd13, 4'd14, 4'd15, 4'd9, 4'd8, 4'd5};
    for (int i = 0; i < 15; i++) applyStimulus(1'b1, frame[i]);
    checkOutput("post reset not done early", 32'(out_valid), 0);
    applyStimulus(1'b1, frame[15]);
    in_valid = 1'b0;
    checkResult("post reset", 3, 4, 0);
    finishHandshake("post reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
